// File: rtl/nbit_rot_pipe.sv
// Pipelined N-bit barrel rotator/shifter with a valid/ready handshake on both sides.
// Stage k moves the operand by 2^k positions when bit k of its amount is set.
module nbit_rot_pipe #(
  parameter  int N = 8,
  localparam int S = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [S-1:0] rotamt,
  input  logic         dir,
  input  logic         mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Y
);

  function automatic logic [N-1:0] move_stage(input logic [N-1:0] d, input int m,
                                              input logic dr, input logic md);
    logic [N-1:0] r;
    if (!dr) r = md ? (d << m) : ((d << m) | (d >> (N - m)));
    else     r = md ? (d >> m) : ((d >> m) | (d << (N - m)));
    return r;
  endfunction

  logic [S-1:0] vld_w;
  logic [S-1:0] dir_w;
  logic [S-1:0] mode_w;
  logic [N-1:0] data_w [S];
  logic [S-1:0] amt_w  [S];
  logic [S-1:0] adv;
  logic         chain_full;

  // A stage may advance unless it and every stage downstream of it are full and the
  // consumer is stalling; only registered valids and out_ready feed this chain.
  always_comb begin
    chain_full = 1'b1;
    adv        = '0;
    for (int k = S - 1; k >= 0; k--) begin
      chain_full = chain_full & vld_w[k];
      adv[k]     = out_ready | ~chain_full;
    end
  end

  for (genvar k = 0; k < S; k++) begin : g_stage
    logic         src_vld, src_dir, src_mode;
    logic [N-1:0] src_data;
    logic [S-1:0] src_amt;

    logic         vld_q, vld_d;
    logic         dir_q, dir_d;
    logic         mode_q, mode_d;
    logic [N-1:0] data_q, data_d;
    logic [S-1:0] amt_q, amt_d;

    if (k == 0) begin : g_src_in
      assign src_vld  = in_valid;
      assign src_data = A;
      assign src_amt  = rotamt;
      assign src_dir  = dir;
      assign src_mode = mode;
    end else begin : g_src_prev
      assign src_vld  = vld_w[k-1];
      assign src_data = data_w[k-1];
      assign src_amt  = amt_w[k-1];
      assign src_dir  = dir_w[k-1];
      assign src_mode = mode_w[k-1];
    end

    always_comb begin
      vld_d  = vld_q;
      data_d = data_q;
      amt_d  = amt_q;
      dir_d  = dir_q;
      mode_d = mode_q;
      if (adv[k]) begin
        vld_d  = src_vld;
        data_d = src_amt[k] ? move_stage(src_data, 1 << k, src_dir, src_mode) : src_data;
        amt_d  = src_amt;
        dir_d  = src_dir;
        mode_d = src_mode;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vld_q  <= 1'b0;
        data_q <= '0;
        amt_q  <= '0;
        dir_q  <= 1'b0;
        mode_q <= 1'b0;
      end else begin
        vld_q  <= vld_d;
        data_q <= data_d;
        amt_q  <= amt_d;
        dir_q  <= dir_d;
        mode_q <= mode_d;
      end
    end

    assign vld_w[k]  = vld_q;
    assign data_w[k] = data_q;
    assign amt_w[k]  = amt_q;
    assign dir_w[k]  = dir_q;
    assign mode_w[k] = mode_q;
  end

  // The last stage keeps its move metadata for observability; nothing consumes it.
  logic meta_unused;
  assign meta_unused = ^{amt_w[S-1], dir_w[S-1], mode_w[S-1]};

  assign in_ready  = adv[0];
  assign out_valid = vld_w[S-1];
  assign Y         = data_w[S-1];

endmodule
